// File: rtl/data_unpacker.sv
// data_unpacker: replays full N-value vectors downstream as chunks of N, M or 1 values.
// Chunk size comes from per-chain firmware bytes written over the config bus while not tracing.
module data_unpacker #(
    parameter int unsigned N                  = 8,
    parameter int unsigned M                  = 2,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MAX_CHAINS         = 4,
    parameter int unsigned PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                tracing,
    input  logic [7:0]                                          configId,
    input  logic [7:0]                                          configData,
    input  logic                                                valid_in,
    output logic                                                ready_up,
    input  logic [((MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1)-1:0] chainId_in,
    input  logic [DATA_WIDTH*N-1:0]                             vector_in,
    output logic                                                valid_out,
    input  logic                                                ready_down,
    output logic [$clog2(N):0]                                  chunk_len,
    output logic [DATA_WIDTH*N-1:0]                             vector_out
);

    localparam int unsigned VEC_W   = DATA_WIDTH * N;
    localparam int unsigned LEN_W   = $clog2(N) + 1;
    localparam int unsigned IDX_W   = $clog2(N);
    localparam int unsigned SH_W    = $clog2(VEC_W) + 1;
    localparam int unsigned CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Drain state and registered outputs
    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [LEN_W-1:0]   r_len;
    logic [IDX_W-1:0]   r_last_idx;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid_out;
    logic [VEC_W-1:0]   r_vector_out;
    logic [LEN_W-1:0]   r_chunk_len;

    // Configuration state
    logic [7:0]         r_firmware [MAX_CHAINS];
    logic [7:0]         r_byte_cnt;

    // Next-state values
    state_t             w_state;
    logic [VEC_W-1:0]   w_vec;
    logic [LEN_W-1:0]   w_len;
    logic [IDX_W-1:0]   w_last_idx;
    logic [IDX_W-1:0]   w_idx;
    logic               w_valid_out;
    logic [VEC_W-1:0]   w_vector_out;
    logic [LEN_W-1:0]   w_chunk_len;

    logic               w_ready_up;
    logic               w_accept;
    logic               w_is_last;
    logic [7:0]         w_fw_sel;
    logic [LEN_W-1:0]   w_in_len;
    logic [IDX_W-1:0]   w_in_last;

    // Chunk length for a firmware code; zero marks "discard"
    function automatic logic [LEN_W-1:0] f_len(input logic [7:0] fw);
        logic [LEN_W-1:0] len;
        case (fw)
            8'd0:    len = LEN_W'(N);
            8'd1:    len = LEN_W'(M);
            8'd2:    len = LEN_W'(1);
            default: len = '0;
        endcase
        return len;
    endfunction

    // Index of the final chunk for a firmware code (N/L - 1)
    function automatic logic [IDX_W-1:0] f_last(input logic [7:0] fw);
        logic [IDX_W-1:0] last;
        case (fw)
            8'd1:    last = IDX_W'(N / M - 1);
            8'd2:    last = IDX_W'(N - 1);
            default: last = '0;
        endcase
        return last;
    endfunction

    // Extract chunk idx of length len from vec into the low lanes, upper lanes zeroed
    function automatic logic [VEC_W-1:0] f_chunk(input logic [VEC_W-1:0] vec,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [IDX_W-1:0] idx);
        logic [VEC_W-1:0] shifted;
        logic [VEC_W-1:0] result;
        shifted = vec >> (SH_W'(idx) * SH_W'(len) * SH_W'(DATA_WIDTH));
        result  = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (LEN_W'(j) < len) begin
                result[j*DATA_WIDTH +: DATA_WIDTH] = shifted[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return result;
    endfunction

    assign w_fw_sel  = r_firmware[chainId_in];
    assign w_in_len  = f_len(w_fw_sel);
    assign w_in_last = f_last(w_fw_sel);
    assign w_is_last = (r_idx == r_last_idx);

    // Upstream may hand over a vector when empty or when the final chunk leaves this cycle
    assign w_ready_up = tracing & rst_n &
                        ((r_state == S_IDLE) | ((r_state == S_DRAIN) & w_is_last & ready_down));
    assign w_accept   = valid_in & w_ready_up;

    assign ready_up   = w_ready_up;
    assign valid_out  = r_valid_out;
    assign chunk_len  = r_chunk_len;
    assign vector_out = r_vector_out;

    // Next-state and output computation
    always_comb begin
        w_state      = r_state;
        w_vec        = r_vec;
        w_len        = r_len;
        w_last_idx   = r_last_idx;
        w_idx        = r_idx;
        w_valid_out  = r_valid_out;
        w_vector_out = r_vector_out;
        w_chunk_len  = r_chunk_len;

        if (!tracing) begin
            w_state      = S_IDLE;
            w_idx        = '0;
            w_valid_out  = 1'b0;
            w_vector_out = '0;
            w_chunk_len  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_valid_out = 1'b0;
                end
                S_DRAIN: begin
                    if (ready_down) begin
                        if (w_is_last) begin
                            w_state      = S_IDLE;
                            w_idx        = '0;
                            w_valid_out  = 1'b0;
                            w_vector_out = '0;
                            w_chunk_len  = '0;
                        end else begin
                            w_idx        = r_idx + IDX_W'(1);
                            w_vector_out = f_chunk(r_vec, r_len, r_idx + IDX_W'(1));
                        end
                    end
                end
                default: begin
                    w_state     = S_IDLE;
                    w_valid_out = 1'b0;
                end
            endcase

            // New vector with a usable chunk size; discarded vectors leave the block idle
            if (w_accept && (w_in_len != '0)) begin
                w_state      = S_DRAIN;
                w_vec        = vector_in;
                w_len        = w_in_len;
                w_last_idx   = w_in_last;
                w_idx        = '0;
                w_valid_out  = 1'b1;
                w_vector_out = f_chunk(vector_in, w_in_len, '0);
                w_chunk_len  = w_in_len;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_len        <= '0;
            r_last_idx   <= '0;
            r_idx        <= '0;
            r_valid_out  <= 1'b0;
            r_vector_out <= '0;
            r_chunk_len  <= '0;
        end else begin
            r_state      <= w_state;
            r_vec        <= w_vec;
            r_len        <= w_len;
            r_last_idx   <= w_last_idx;
            r_idx        <= w_idx;
            r_valid_out  <= w_valid_out;
            r_vector_out <= w_vector_out;
            r_chunk_len  <= w_chunk_len;
        end
    end

    // Firmware bytes arrive in chain order; the counter saturates so late bytes never wrap around
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            for (int c = 0; c < int'(MAX_CHAINS); c++) begin
                r_firmware[c] <= INITIAL_FIRMWARE[c*8 +: 8];
            end
        end else if (!tracing) begin
            if (configId == 8'(PERSONAL_CONFIG_ID)) begin
                if (r_byte_cnt < 8'(MAX_CHAINS)) begin
                    r_firmware[CHAIN_W'(r_byte_cnt)] <= configData;
                end
                if (r_byte_cnt != 8'hFF) begin
                    r_byte_cnt <= r_byte_cnt + 8'd1;
                end
            end else begin
                r_byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker: directed scenarios plus random traffic against a chunk-queue model.
module tb_data_unpacker;

    localparam int unsigned N     = 8;
    localparam int unsigned M     = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned MAXC  = 4;
    localparam int unsigned VEC_W = N * DW;
    localparam int unsigned LEN_W = $clog2(N) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tracing;
    logic [7:0]       configId;
    logic [7:0]       configData;
    logic             valid_in;
    logic             ready_up;
    logic [1:0]       chainId_in;
    logic [VEC_W-1:0] vector_in;
    logic             valid_out;
    logic             ready_down;
    logic [LEN_W-1:0] chunk_len;
    logic [VEC_W-1:0] vector_out;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [VEC_W-1:0] vec;
    } chunk_t;

    chunk_t      exp_q[$];
    int unsigned fw_m[MAXC];
    int unsigned cnt_m;
    int          errors = 0;
    int          checks = 0;

    data_unpacker #(
        .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MAXC), .PERSONAL_CONFIG_ID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .configId(configId),
        .configData(configData), .valid_in(valid_in), .ready_up(ready_up),
        .chainId_in(chainId_in), .vector_in(vector_in), .valid_out(valid_out),
        .ready_down(ready_down), .chunk_len(chunk_len), .vector_out(vector_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned len_of(input int unsigned fw);
        case (fw)
            0:       return N;
            1:       return M;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [VEC_W-1:0] seq_vec(input int unsigned base);
        logic [VEC_W-1:0] v;
        for (int j = 0; j < int'(N); j++) v[j*DW +: DW] = DW'(base + j);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int j = 0; j < int'(N); j++) v[j*DW +: DW] = $urandom;
        return v;
    endfunction

    // Split a vector into the chunk sequence a consumer should see, oldest value first
    task automatic push_vector(input logic [VEC_W-1:0] v, input int unsigned L);
        for (int unsigned c = 0; c < N / L; c++) begin
            chunk_t e;
            e.len = LEN_W'(L);
            e.vec = '0;
            for (int unsigned j = 0; j < L; j++) e.vec[j*DW +: DW] = v[(c*L + j)*DW +: DW];
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < int'(MAXC); c++) fw_m[c] = 0;
        cnt_m = 0;
    endtask

    // One clock: check settled outputs, then advance the model across the rising edge
    task automatic tick();
        logic exp_rdy;
        logic hs;
        logic acc;
        #1;
        exp_rdy = tracing && rst_n && (exp_q.size() == 0 || (exp_q.size() == 1 && ready_down));
        check("ready_up", VEC_W'(ready_up), VEC_W'(exp_rdy));
        check("valid_out", VEC_W'(valid_out), VEC_W'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("chunk_len", VEC_W'(chunk_len), VEC_W'(exp_q[0].len));
            check("vector_out", vector_out, exp_q[0].vec);
        end
        hs  = (exp_q.size() != 0) && ready_down;
        acc = valid_in && exp_rdy;
        @(posedge clk);
        if (!tracing) begin
            exp_q.delete();
            if (configId == 8'd0) begin
                if (cnt_m < MAXC) fw_m[cnt_m] = configData;
                if (cnt_m < 255) cnt_m++;
            end else begin
                cnt_m = 0;
            end
        end else begin
            if (hs) void'(exp_q.pop_front());
            if (acc && len_of(fw_m[chainId_in]) != 0) push_vector(vector_in, len_of(fw_m[chainId_in]));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] cfg_bytes [5];
        logic       rd_pat [4];
        cfg_bytes[0] = 8'd2; cfg_bytes[1] = 8'd1; cfg_bytes[2] = 8'd0; cfg_bytes[3] = 8'd3; cfg_bytes[4] = 8'd2;
        rd_pat[0] = 1'b1; rd_pat[1] = 1'b0; rd_pat[2] = 1'b0; rd_pat[3] = 1'b1;

        rst_n = 1'b0; tracing = 1'b0; configId = 8'hFF; configData = '0;
        valid_in = 1'b0; ready_down = 1'b1; chainId_in = '0; vector_in = '0;
        model_reset();

        // Reset state
        #2;
        check("rst_valid_out", VEC_W'(valid_out), '0);
        check("rst_vector_out", vector_out, '0);
        check("rst_chunk_len", VEC_W'(chunk_len), '0);
        check("rst_ready_up", VEC_W'(ready_up), '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; tracing = 1'b1;

        // Mode N, two vectors back-to-back
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = seq_vec(0); tick();
        vector_in = seq_vec(8); tick();
        valid_in = 1'b0; tick(); tick();

        // Configure chains {1-value, M, N, discard}; fifth byte must be ignored
        tracing = 1'b0; configId = 8'd0;
        for (int i = 0; i < 5; i++) begin configData = cfg_bytes[i]; tick(); end
        configId = 8'd7; tick();
        tracing = 1'b1;

        // Mode M on chain 1
        valid_in = 1'b1; chainId_in = 2'd1; vector_in = seq_vec(10); tick();
        valid_in = 1'b0; repeat (5) tick();

        // Mode 1 on chain 0 with downstream stalls
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = seq_vec(0); ready_down = 1'b1; tick();
        valid_in = 1'b0;
        for (int i = 0; i < 24; i++) begin ready_down = rd_pat[i % 4]; tick(); end
        ready_down = 1'b1; repeat (2) tick();

        // Chain 3 discards its vectors
        valid_in = 1'b1; chainId_in = 2'd3; vector_in = rand_vec(); tick();
        vector_in = rand_vec(); tick();
        valid_in = 1'b0; repeat (3) tick();

        // Tracing dropped part-way through a mode-M drain, then a fresh vector
        valid_in = 1'b1; chainId_in = 2'd1; vector_in = seq_vec(32); tick();
        valid_in = 1'b0; tick(); tick();
        tracing = 1'b0; tick();
        tracing = 1'b1; tick();
        valid_in = 1'b1; chainId_in = 2'd1; vector_in = seq_vec(40); tick();
        valid_in = 1'b0; repeat (5) tick();

        // Random traffic with occasional reconfiguration windows
        for (int i = 0; i < 400; i++) begin
            tracing    = ($urandom_range(0, 29) != 0);
            configId   = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'd7;
            configData = 8'($urandom_range(0, 3));
            valid_in   = ($urandom_range(0, 2) != 0);
            chainId_in = 2'($urandom_range(0, 3));
            vector_in  = rand_vec();
            ready_down = ($urandom_range(0, 3) != 0);
            tick();
        end
        tracing = 1'b1; configId = 8'd7; valid_in = 1'b0; ready_down = 1'b1;
        repeat (10) tick();

        // Reset in the middle of a mode-1 drain
        tracing = 1'b0; tick();
        configId = 8'd0; configData = 8'd2; tick();
        configId = 8'd7; tracing = 1'b1;
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = seq_vec(100); tick();
        valid_in = 1'b0; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_valid_out", VEC_W'(valid_out), '0);
        check("abort_vector_out", vector_out, '0);
        check("abort_chunk_len", VEC_W'(chunk_len), '0);
        check("abort_ready_up", VEC_W'(ready_up), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Firmware is back to mode N after reset
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = seq_vec(200); tick();
        valid_in = 1'b0; repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
